// File: rtl/mau_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mau_pkg
// Purpose  : Shared encodings for the memory-access-unit store channel:
//            access sizes, error codes and the store FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package mau_pkg;

  // Access size encoding as produced by the execute stage
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_IDLE = 2'd3;

  // Error codes reported to the core
  localparam logic [1:0] ERR_MISALIGN = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage : mau_pkg
`default_nettype wire

// File: rtl/mau_store_if.sv
`default_nettype none
// ============================================================================
// Module   : mau_store_if
// Purpose  : Bundles the store request, data-memory write port and status
//            signals of the store channel. master = store unit, slave = the
//            core/memory environment around it.
// Revision : 1.0 - initial release
// ============================================================================
interface mau_store_if;
  // Store request from the execute stage
  logic [3:0]  cycle_cnt;
  logic [31:0] exu_store_addr;
  logic [31:0] exu_store_data;
  logic        exu_store_en;
  logic [1:0]  exu_store_size;
  // Data-memory write port
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  // Status back to the core
  logic        mau_store_busy;
  logic        mau_store_done;
  logic        mau_store_err;
  logic [1:0]  mau_store_err_code;
  logic [31:0] mau_store_err_addr;
  logic        mau_store_ovr;

  modport master (
    input  cycle_cnt, exu_store_addr, exu_store_data, exu_store_en, exu_store_size,
    input  mem_ready,
    output mem_req, mem_addr, mem_wdata, mem_wstrb,
    output mau_store_busy, mau_store_done, mau_store_err,
    output mau_store_err_code, mau_store_err_addr, mau_store_ovr
  );

  modport slave (
    output cycle_cnt, exu_store_addr, exu_store_data, exu_store_en, exu_store_size,
    output mem_ready,
    input  mem_req, mem_addr, mem_wdata, mem_wstrb,
    input  mau_store_busy, mau_store_done, mau_store_err,
    input  mau_store_err_code, mau_store_err_addr, mau_store_ovr
  );

endinterface : mau_store_if
`default_nettype wire

// File: rtl/mau_store_lane.sv
`default_nettype none
// ============================================================================
// Module   : mau_store_lane
// Purpose  : Purely combinational byte-lane formatter. Replicates the store
//            data across lanes, builds the write strobes from the byte offset
//            and flags naturally-misaligned accesses. Shared with the load side.
// Revision : 1.0 - initial release
// ============================================================================
module mau_store_lane
  import mau_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        misaligned_o
);

  // Lane replication and strobe generation; idle size writes no lanes
  always_comb begin
    wdata_o      = data_i;
    wstrb_o      = 4'b0000;
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      SIZE_HALF: begin
        wdata_o      = {2{data_i[15:0]}};
        wstrb_o      = 4'b0011 << off_i;
        misaligned_o = off_i[0];
      end
      SIZE_WORD: begin
        wdata_o      = data_i;
        wstrb_o      = 4'b1111;
        misaligned_o = |off_i;
      end
      default: begin
        wstrb_o = 4'b0000;
      end
    endcase
  end

endmodule : mau_store_lane
`default_nettype wire

// File: rtl/mau_store.sv
`default_nettype none
// ============================================================================
// Module   : mau_store
// Purpose  : Store channel of the memory-access unit. Captures the execute
//            stage store request, checks alignment and range, drives a
//            req/ready write with a watchdog and reports done/error.
// Revision : 1.0 - initial release
// ============================================================================
module mau_store
  import mau_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE     = 32'h0001_0000,
  parameter int          DMEM_WORDS    = 4096,
  parameter int          CAPTURE_CYCLE = 5,
  parameter int          TIMEOUT       = 15
) (
  input  logic        hclk,
  input  logic        hrstn,
  mau_store_if.master bus
);

  // Upper bound kept in 33 bits so BASE + size can never wrap
  localparam logic [32:0] c_LIMIT     = {1'b0, DMEM_BASE} + (33'(DMEM_WORDS) * 33'd4);
  localparam logic [7:0]  c_WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0]  c_CAP       = 4'(CAPTURE_CYCLE);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] req_addr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic [1:0]  err_code_q;
  logic [31:0] err_addr_q;
  logic        ovr_q;

  logic        w_capture;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_timeout;
  logic [31:0] w_lane_wdata;
  logic [3:0]  w_lane_wstrb;

  assign w_capture = (bus.cycle_cnt == c_CAP) && bus.exu_store_en &&
                     (bus.exu_store_size != SIZE_IDLE);

  assign w_out_of_range = ({1'b0, bus.exu_store_addr} < {1'b0, DMEM_BASE}) ||
                          ({1'b0, bus.exu_store_addr} >= c_LIMIT);

  assign w_timeout = (state_q == ST_REQ) && !bus.mem_ready && (wait_q == c_WAIT_LAST);

  mau_store_lane u_lane (
    .size_i       (bus.exu_store_size),
    .off_i        (bus.exu_store_addr[1:0]),
    .data_i       (bus.exu_store_data),
    .wdata_o      (w_lane_wdata),
    .wstrb_o      (w_lane_wstrb),
    .misaligned_o (w_misaligned)
  );

  // Next-state and watchdog counter logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (w_capture) begin
          state_d = (w_misaligned || w_out_of_range) ? ST_ERR : ST_REQ;
          wait_d  = 8'd0;
        end
      end
      ST_REQ: begin
        if (bus.mem_ready) begin
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (w_timeout) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and watchdog registers
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q <= ST_IDLE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Request capture, error reporting and sticky overrun flag
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      req_addr_q  <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      err_code_q  <= 2'd0;
      err_addr_q  <= 32'd0;
      ovr_q       <= 1'b0;
    end else begin
      if (w_capture && (state_q != ST_IDLE)) begin
        ovr_q <= 1'b1;
      end
      if (w_capture && (state_q == ST_IDLE)) begin
        if (w_misaligned || w_out_of_range) begin
          err_code_q <= w_misaligned ? ERR_MISALIGN : ERR_RANGE;
          err_addr_q <= bus.exu_store_addr;
        end else begin
          req_addr_q  <= bus.exu_store_addr;
          mem_addr_q  <= {bus.exu_store_addr[31:2], 2'b00};
          mem_wdata_q <= w_lane_wdata;
          mem_wstrb_q <= w_lane_wstrb;
        end
      end
      if (w_timeout) begin
        err_code_q <= ERR_TIMEOUT;
        err_addr_q <= req_addr_q;
      end
    end
  end

  assign bus.mem_req            = (state_q == ST_REQ);
  assign bus.mem_addr           = mem_addr_q;
  assign bus.mem_wdata          = mem_wdata_q;
  assign bus.mem_wstrb          = mem_wstrb_q;
  assign bus.mau_store_busy     = (state_q != ST_IDLE);
  assign bus.mau_store_done     = (state_q == ST_DONE);
  assign bus.mau_store_err      = (state_q == ST_ERR);
  assign bus.mau_store_err_code = err_code_q;
  assign bus.mau_store_err_addr = err_addr_q;
  assign bus.mau_store_ovr      = ovr_q;

endmodule : mau_store
`default_nettype wire

// File: tb/tb_mau_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_mau_store
// Purpose  : Scoreboard bench for mau_store. Stores are issued with a
//            reference-model expectation pushed to a queue; a monitor pops
//            and compares whenever the DUT requests memory, completes or
//            reports an error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mau_store;
  import mau_pkg::*;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          WORDS = 4096;
  localparam int          CAP   = 5;
  localparam int          TMO   = 15;
  localparam longint      LIMIT = longint'(BASE) + 4 * longint'(WORDS);

  localparam int K_OK = 0, K_BAD = 1, K_TMO = 2, K_ABORT = 3;

  // Cycle numbering: cyc counts posedges; a capture on the edge that makes
  // cyc == e0 shows its first busy state at the following negedge.
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  code;
    logic [31:0] eaddr;
    int          e0;
    int          end_cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  logic hclk  = 1'b0;
  logic hrstn = 1'b0;
  int   cyc   = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_end = -10;
  int   ovr_cyc = 32'h7FFF_FFFF;
  int   resp_delay = 0;
  int   rj = 0;
  int   busy_run = 0;
  bit   req_seen = 1'b0;

  mau_store_if bus ();

  mau_store #(
    .DMEM_BASE     (BASE),
    .DMEM_WORDS    (WORDS),
    .CAPTURE_CYCLE (CAP),
    .TIMEOUT       (TMO)
  ) dut (
    .hclk  (hclk),
    .hrstn (hrstn),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outcome of one accepted store from its architectural rules
  function automatic exp_t model(logic [31:0] addr, logic [31:0] data, logic [1:0] size,
                                 int delay, int e0, bit abort);
    exp_t   e;
    int     nbytes = 1 << size;
    int     off    = int'(addr % 4);
    longint a      = longint'({32'h0, addr});
    e.addr  = addr & 32'hFFFF_FFFC;
    e.wstrb = 4'(((1 << nbytes) - 1) << off);
    if (nbytes == 1)      e.wdata = {24'h0, data[7:0]} * 32'h0101_0101;
    else if (nbytes == 2) e.wdata = {16'h0, data[15:0]} * 32'h0001_0001;
    else                  e.wdata = data;
    e.e0    = e0;
    e.eaddr = addr;
    e.code  = 2'd0;
    if ((addr % nbytes) != 0) begin
      e.kind = K_BAD; e.code = 2'd0; e.end_cyc = e0;
    end else if (a < longint'(BASE) || a >= LIMIT) begin
      e.kind = K_BAD; e.code = 2'd1; e.end_cyc = e0;
    end else if (abort) begin
      e.kind = K_ABORT; e.end_cyc = e0 + 1000;
    end else if (delay >= TMO) begin
      e.kind = K_TMO; e.code = 2'd2; e.end_cyc = e0 + TMO;
    end else begin
      e.kind = K_OK; e.end_cyc = e0 + delay + 1;
    end
    return e;
  endfunction

  // One cycle of request inputs that must never be captured
  task automatic noise();
    int r = int'($urandom % 3);
    int cc = int'($urandom % 16);
    if (cc == CAP) cc = 0;
    bus.exu_store_addr = $urandom;
    bus.exu_store_data = $urandom;
    bus.exu_store_size = 2'($urandom);
    if (r == 0) begin
      bus.cycle_cnt = 4'(cc); bus.exu_store_en = 1'($urandom);
    end else if (r == 1) begin
      bus.cycle_cnt = 4'(CAP); bus.exu_store_en = 1'b0;
    end else begin
      bus.cycle_cnt = 4'(CAP); bus.exu_store_en = 1'b1; bus.exu_store_size = SIZE_IDLE;
    end
  endtask

  // Called just after a negedge; presents one capturing request
  task automatic issue(logic [31:0] addr, logic [31:0] data, logic [1:0] size,
                       int delay, bit abort);
    exp_t e;
    bus.cycle_cnt = 4'(CAP);
    bus.exu_store_en = 1'b1;
    bus.exu_store_size = size;
    bus.exu_store_addr = addr;
    bus.exu_store_data = data;
    if (cyc >= busy_end + 1) begin
      e = model(addr, data, size, delay, cyc + 1, abort);
      resp_delay = delay;
      q.push_back(e);
      busy_end = e.end_cyc;
    end else if (ovr_cyc > cyc + 1) begin
      ovr_cyc = cyc + 1;
    end
    @(negedge hclk);
    noise();
  endtask

  task automatic wait_idle(int gap);
    for (int n = 0; n < 200 && cyc < busy_end + 1 + gap; n++) begin
      @(negedge hclk);
      noise();
    end
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_busy"}, bus.mau_store_busy, 0);
    chk({tag, "_done"}, bus.mau_store_done, 0);
    chk({tag, "_err"}, bus.mau_store_err, 0);
    chk({tag, "_ovr"}, bus.mau_store_ovr, 0);
    chk({tag, "_err_code"}, bus.mau_store_err_code, 0);
    chk({tag, "_err_addr"}, bus.mau_store_err_addr, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, bus.mem_wstrb, 0);
  endtask

  // Memory responder: ready after resp_delay REQ cycles, random when idle
  always @(negedge hclk) begin
    if (!hrstn) begin
      rj = 0;
      bus.mem_ready = 1'b0;
    end else if (bus.mem_req) begin
      bus.mem_ready = (rj >= resp_delay);
      rj++;
    end else begin
      rj = 0;
      bus.mem_ready = 1'($urandom);
    end
  end

  // Monitor: compare DUT events against the head of the scoreboard
  always @(negedge hclk) begin
    if (!hrstn) begin
      req_seen = 1'b0;
      busy_run = 0;
    end else begin
      busy_run = bus.mau_store_busy ? busy_run + 1 : 0;
      chk("ovr", bus.mau_store_ovr, (cyc >= ovr_cyc));
      if (bus.mem_req) begin
        if (q.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          me = q[0];
          if (!req_seen) begin
            chk("req_for_bad_store", (me.kind == K_BAD), 0);
            chk("req_cycle", cyc, me.e0);
          end
          chk("mem_addr", bus.mem_addr, me.addr);
          chk("mem_wdata", bus.mem_wdata, me.wdata);
          chk("mem_wstrb", bus.mem_wstrb, me.wstrb);
        end
        req_seen = 1'b1;
      end else begin
        req_seen = 1'b0;
      end
      if (bus.mau_store_done) begin
        if (q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          me = q.pop_front();
          chk("done_kind", me.kind, K_OK);
          chk("done_cycle", cyc, me.end_cyc);
          chk("done_busy_len", busy_run, me.end_cyc - me.e0 + 1);
        end
      end
      if (bus.mau_store_err) begin
        if (q.size() == 0) chk("err_unexpected", 1, 0);
        else begin
          me = q.pop_front();
          chk("err_kind", (me.kind == K_BAD || me.kind == K_TMO), 1);
          chk("err_code", bus.mau_store_err_code, me.code);
          chk("err_addr", bus.mau_store_err_addr, me.eaddr);
          chk("err_cycle", cyc, me.end_cyc);
          chk("err_busy_len", busy_run, me.end_cyc - me.e0 + 1);
        end
      end
    end
  end

  initial begin
    bus.cycle_cnt = 4'd0;
    bus.exu_store_en = 1'b0;
    bus.exu_store_size = SIZE_IDLE;
    bus.exu_store_addr = 32'd0;
    bus.exu_store_data = 32'd0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge hclk);
    chk_reset_values("reset");
    #2 hrstn = 1'b1;
    @(negedge hclk);

    // Directed cases
    issue(32'h0001_0008, 32'hDEAD_BEEF, SIZE_WORD, 0, 1'b0); wait_idle(2);
    issue(32'h0001_0003, 32'h0000_00A5, SIZE_BYTE, 0, 1'b0); wait_idle(2);
    issue(32'h0001_0001, 32'h0000_1234, SIZE_HALF, 0, 1'b0); wait_idle(2);
    issue(32'h0001_4000, 32'h1111_2222, SIZE_WORD, 0, 1'b0); wait_idle(2);
    issue(32'h0000_FFFC, 32'h3333_4444, SIZE_WORD, 0, 1'b0); wait_idle(2);
    issue(32'h0001_3FFC, 32'h5555_6666, SIZE_WORD, 0, 1'b0); wait_idle(2);
    issue(32'h0001_0010, 32'h7777_8888, SIZE_WORD, 255, 1'b0); wait_idle(1);
    issue(32'h0001_0014, 32'h9999_AAAA, SIZE_WORD, 0, 1'b0); wait_idle(2);
    issue(32'h0001_0020, 32'hCAFE_F00D, SIZE_WORD, 3, 1'b0);
    issue(32'h0001_0024, 32'h0BAD_0BAD, SIZE_WORD, 0, 1'b0);
    wait_idle(3);
    chk("ovr_sticky", bus.mau_store_ovr, 1);

    // Reset while a write is outstanding
    issue(32'h0001_0030, 32'h1234_5678, SIZE_WORD, 255, 1'b1);
    repeat (3) begin @(negedge hclk); noise(); end
    #2 hrstn = 1'b0;
    #1 chk_reset_values("midreq_reset");
    q.delete();
    busy_end = cyc;
    ovr_cyc = 32'h7FFF_FFFF;
    @(negedge hclk);
    #2 hrstn = 1'b1;
    @(negedge hclk);
    noise();

    // Randomized stores
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a, d;
      logic [1:0]  s;
      int          dl, r;
      wait_idle(int'($urandom % 4));
      s = 2'($urandom % 3);
      r = int'($urandom % 8);
      if (r <= 4)      a = BASE + ($urandom % (4 * WORDS));
      else if (r == 5) a = BASE - 32'd8 + ($urandom % 16);
      else if (r == 6) a = 32'(LIMIT) - 32'd8 + ($urandom % 16);
      else             a = $urandom;
      d = $urandom;
      if (s == SIZE_BYTE) d = d & 32'h0000_00FF;
      if (s == SIZE_HALF) d = d & 32'h0000_FFFF;
      r = int'($urandom % 10);
      if (r < 6)       dl = int'($urandom % 4);
      else if (r < 8)  dl = 4 + int'($urandom % 11);
      else if (r == 8) dl = 14 + int'($urandom % 2);
      else             dl = 20 + int'($urandom % 20);
      issue(a, d, s, dl, 1'b0);
      if (busy_end > cyc && ($urandom % 8) == 0) begin
        issue($urandom, $urandom, SIZE_WORD, 0, 1'b0);
      end
    end

    wait_idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mau_store
`default_nettype wire
